// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes on both sides and a registered result.
// Optional iterative signed multiply on arithmetic opcode 111, enabled by `define ALU_PIPE_MUL_EN.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               zero,
  output logic               neg,
  output logic               busy
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [W2-1:0] ONE = {{(W2-1){1'b0}}, 1'b1};

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_mul;
  logic             mul_last;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t         state_q, state_d;
  logic [W2-1:0]  y_q, y_d;
  logic           zero_q, zero_d;
  logic           neg_q, neg_d;
  logic           out_valid_q, out_valid_d;
  logic [W2-1:0]  a_ext, b_ext, alu_res;
  logic           accept, out_xfer, load_alu;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

  always_comb begin
    alu_res = '0;
    if (!sel[3]) begin
      case (sel[2:0])
        3'd0: alu_res = a_ext + ONE;
        3'd1: alu_res = a_ext - ONE;
        3'd2: alu_res = a_ext << 2;
        3'd3: alu_res = b_ext + ONE;
        3'd4: alu_res = b_ext - ONE;
        3'd5: alu_res = b_ext << 1;
        3'd6: alu_res = a_ext + b_ext;
        3'd7: alu_res = a_ext << 2;
        default: alu_res = '0;
      endcase
    end else begin
      case (sel[2:0])
        3'd0: alu_res = ~a_ext;
        3'd1: alu_res = ~b_ext;
        3'd2: alu_res = a_ext & b_ext;
        3'd3: alu_res = a_ext | b_ext;
        3'd4: alu_res = a_ext ^ b_ext;
        3'd5: alu_res = ~(a_ext ^ b_ext);
        3'd6: alu_res = ~(a_ext & b_ext);
        3'd7: alu_res = ~(a_ext + b_ext);
        default: alu_res = '0;
      endcase
    end
  end

  // FSM outputs; reset masks the handshake and status outputs immediately.
  always_comb begin
    in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    out_valid = out_valid_q && !rst;
    busy      = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    busy      = !rst && (state_q == MUL);
`endif
  end

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef ALU_PIPE_MUL_EN
  assign is_mul   = (sel == 4'b0111);
  assign mul_last = (state_q == MUL) && (cnt_q == LAST);
  assign load_alu = accept && !is_mul;
`else
  assign load_alu = accept;
`endif

  always_comb begin
    state_d = state_q;
`ifdef ALU_PIPE_MUL_EN
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_last) state_d = IDLE;
    endcase
`endif
  end

  always_comb begin
    y_d         = y_q;
    out_valid_d = out_xfer ? 1'b0 : out_valid_q;
`ifdef ALU_PIPE_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept && is_mul) begin
      acc_d    = '0;
      mcand_d  = a_ext;
      mplier_d = b;
      cnt_d    = '0;
    end
    // Shift-add over the WIDTH bits of b; the sign bit carries weight -2^(WIDTH-1).
    if (state_q == MUL) begin
      if (mplier_q[0]) acc_d = mul_last ? (acc_q - mcand_q) : (acc_q + mcand_q);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (mul_last) begin
        y_d         = acc_d;
        out_valid_d = 1'b1;
      end
    end
`endif
    if (load_alu) begin
      y_d         = alu_res;
      out_valid_d = 1'b1;
    end
    zero_d = (y_d == '0);
    neg_d  = y_d[W2-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_PIPE_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign y    = y_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=4): directed vectors, backpressure, reset abort, random traffic.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b, sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero, neg, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int         xfer_cyc[$];
  logic       rand_bp = 1'b0;

`ifdef ALU_PIPE_MUL_EN
  localparam int         MUL_BUSY = 4;
  localparam int         MUL_LAT  = 5;
  localparam logic [7:0] EXP_33   = 8'hF1;
`else
  localparam int         MUL_BUSY = 0;
  localparam int         MUL_LAT  = 1;
  localparam logic [7:0] EXP_33   = 8'hF4;
`endif

  alu_pipe #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .neg(neg), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Reference: signed integer arithmetic, truncated to 8 bits.
  function automatic logic [7:0] model(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] is);
    int sa, sb, r;
    sa = $signed(ia);
    sb = $signed(ib);
    r = 0;
    if (!is[3]) begin
      case (is[2:0])
        3'd0: r = sa + 1;
        3'd1: r = sa - 1;
        3'd2: r = sa * 4;
        3'd3: r = sb + 1;
        3'd4: r = sb - 1;
        3'd5: r = sb * 2;
        3'd6: r = sa + sb;
`ifdef ALU_PIPE_MUL_EN
        3'd7: r = sa * sb;
`else
        3'd7: r = sa * 4;
`endif
        default: r = 0;
      endcase
    end else begin
      case (is[2:0])
        3'd0: r = ~sa;
        3'd1: r = ~sb;
        3'd2: r = sa & sb;
        3'd3: r = sa | sb;
        3'd4: r = sa ^ sb;
        3'd5: r = ~(sa ^ sb);
        3'd6: r = ~(sa & sb);
        3'd7: r = ~(sa + sb);
        default: r = 0;
      endcase
    end
    return r[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] is,
                       input logic [7:0] expv, input bit push);
    int t;
    a = ia; b = ib; sel = is; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      t++;
      if (t > 1000) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: y=%0h with no result expected", y);
      end else begin
        e = exp_q.pop_front();
        chk("result_y", y, e);
        chk("result_zero", zero, (e == 8'h00));
        chk("result_neg", neg, e[7]);
      end
    end
  end

  initial begin
    int busy_cnt, lat;
    logic [3:0] ra, rb, rs;

    rst = 1'b1; in_valid = 1'b1; a = 4'h7; b = 4'h0; sel = 4'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Increment, one-cycle latency
    issue(4'h7, 4'h0, 4'b0000, 8'h08, 1);
    @(negedge clk);
    chk("inc_valid", out_valid, 1);
    chk("inc_y", y, 8'h08);
    chk("inc_zero", zero, 0);
    chk("inc_neg", neg, 0);
    drain();

    issue(4'h8, 4'h0, 4'b0010, 8'hE0, 1);
    issue(4'h3, 4'h4, 4'b1111, 8'hF8, 1);
    issue(4'h1, 4'h0, 4'b0001, 8'h00, 1);
    drain();

    // Back-to-back stream of single-cycle ops
    xfer_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 4'($urandom);
      if (rs == 4'b0111) rs = 4'b1000;
      issue(ra, rb, rs, model(ra, rb, rs), 1);
    end
    drain();
    chk("stream_count", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) chk("stream_span", xfer_cyc[7] - xfer_cyc[0], 7);

    // Backpressure: second bundle waits, first result held
    out_ready = 1'b0;
    issue(4'h2, 4'h0, 4'b0000, 8'h03, 1);
    fork
      issue(4'h5, 4'h3, 4'b1010, 8'h01, 1);
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y_stable", y, 8'h03);
      chk("bp_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_y", y, 8'h01);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain();

    // Opcode 0111: multiply or shift depending on build
    issue(4'hD, 4'h5, 4'b0111, EXP_33, 1);
    busy_cnt = 0; lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (busy) begin
        busy_cnt++;
        chk("mul_in_ready", in_ready, 0);
      end
    end
    chk("mul_busy_cycles", busy_cnt, MUL_BUSY);
    chk("mul_latency", lat, MUL_LAT);
    drain();

    // Reset in the second cycle of a multiply aborts it
`ifdef ALU_PIPE_MUL_EN
    issue(4'h3, 4'h6, 4'b0111, 8'h12, 0);
`else
    issue(4'h3, 4'h6, 4'b0111, 8'h0C, 1);
`endif
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_in_ready", in_ready, 0);
    chk("abort_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    #1;
    issue(4'hD, 4'h5, 4'b0111, EXP_33, 1);
    drain();

    // Random traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 4'($urandom);
      issue(ra, rb, rs, model(ra, rb, rs), 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operand/opcode bundle offered.
REQ-005 in_ready  output  1  block accepts the bundle this cycle.
REQ-006 a, b  input  WIDTH each  signed two's-complement operands.
REQ-007 sel  input  4  opcode; sel[3]=0 selects arithmetic, sel[3]=1 selects logical.
REQ-008 out_valid  output  1  y, zero and neg hold a valid result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 y  output  2*WIDTH  result.
REQ-011 zero  output  1  y equals 0.
REQ-012 neg  output  1  y[2*WIDTH-1].
REQ-013 busy  output  1  high while a multi-cycle operation is in progress.

Function
REQ-014 a and b shall be sign-extended to 2*WIDTH bits, and every result shall be computed modulo 2^(2*WIDTH).
REQ-015 Arithmetic sel[2:0] encoding: 000 a+1; 001 a-1; 010 a<<2; 011 b+1; 100 b-1; 101 b<<1; 110 a+b; 111 a<<2, or a*b under REQ-027.
REQ-016 Logical sel[2:0] encoding: 000 ~a; 001 ~b; 010 a&b; 011 a|b; 100 a^b; 101 ~(a^b); 110 ~(a&b); 111 ~(a+b).
REQ-017 Transfer rules: input transfers when in_valid&&in_ready; output transfers when out_valid&&out_ready.
REQ-018 in_ready shall equal (state==IDLE) && (!out_valid || out_ready), so input and output transfers can occur in the same cycle.
REQ-019 Single-cycle operations: the result shall appear on y with out_valid=1 on the edge following acceptance (latency 1), giving one result per cycle under no backpressure.
REQ-020 FSM states: IDLE and MUL. IDLE goes to MUL on acceptance of a multiply; MUL returns to IDLE after WIDTH cycles, with out_valid set on that final edge. Latency is WIDTH+1 from acceptance.
REQ-021 busy shall be 1 exactly while in MUL; in_ready shall be 0 throughout MUL.
REQ-022 While out_valid=1 and out_ready=0, y, zero and neg shall remain stable and no new bundle shall be accepted.
REQ-023 out_valid shall clear after an output transfer unless a new result is loaded on the same edge.
REQ-024 zero and neg shall be registered together with y and always be consistent with it.

Reset
REQ-025 When rst=1, the block shall enter IDLE and force out_valid=0, y=0, zero=1, neg=0, busy=0 and in_ready=0, regardless of in_valid.
REQ-026 Reset asserted during MUL shall abort the operation with no result emitted; the first cycle after reset releases shall show in_ready=1.

Configuration
REQ-027 Macro ALU_PIPE_MUL_EN, when defined, shall map arithmetic sel[2:0]=111 to the exact signed product a*b, using the MUL state and WIDTH-cycle iteration.
REQ-028 When ALU_PIPE_MUL_EN is undefined, arithmetic 111 shall be a single-cycle a<<2, the MUL state shall not exist, and busy shall be tied to 0.

Verification (WIDTH=4)
REQ-029 a=4'h7, sel=0000, out_ready=1 -> next cycle y=8'h08, zero=0, neg=0, out_valid=1.
REQ-030 a=4'h8 (-8), sel=0010 -> y=8'hE0, neg=1; then a=4'h3, b=4'h4, sel=1111 -> y=8'hF8.
REQ-031 a=4'h1, sel=0001 -> y=8'h00, zero=1; back-to-back stream of 8 ops with out_ready=1 -> 8 results in 8 consecutive cycles.
REQ-032 out_ready=0 after first result, second bundle held valid -> in_ready=0, y unchanged; out_ready=1 for one cycle -> second result loaded on that edge.
REQ-033 With ALU_PIPE_MUL_EN: a=4'hD (-3), b=4'h5, sel=0111 -> busy=1 for 4 cycles, then y=8'hF1; without the macro -> y=8'hF4 after 1 cycle.
REQ-034 rst pulsed during cycle 2 of MUL -> no out_valid pulse; in_ready=1 the cycle after rst drops; the next op completes correctly.
